// File: rtl/rng_range_draw.sv
// rng_range_draw
//   Turns the raw byte stream of an 8-bit LFSR into values that are uniformly
//   distributed in [0, limit-1]. It uses rejection sampling. The LFSR is
//   advanced only while a sample is being evaluated. Results queue in a small
//   FIFO that the consumer reads through a valid/ready handshake.
//
// Ports
//   clock        rising-edge clock for all state
//   reset_n      synchronous, active-low reset
//   enable       permit starting a new draw while the FIFO has space
//   flush        synchronous clear of the FIFO; aborts a draw in flight
//   limit        range bound (0 encodes 256)
//   rng_q        current LFSR register value
//   rng_step     shift-enable for the LFSR (high in every SAMPLE cycle)
//   out_valid    FIFO head is valid
//   out_ready    consumer accepts the head this cycle
//   out_data     head value, always < the limit it was drawn against
//   out_fallback head value came from the fallback path
//   count        FIFO occupancy
//   rng_zero     sticky flag: rng_q was 0 while sampling (LFSR lock-up)
module rng_range_draw #(
  parameter int DEPTH     = 4,
  parameter int MAX_TRIES = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [7:0]               limit,
  input  logic [7:0]               rng_q,
  output logic                     rng_step,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_fallback,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     rng_zero
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [AW:0]   CNT_FULL  = DEPTH[AW:0];
  localparam logic [TW-1:0] LAST_TRY  = TW'(MAX_TRIES - 1);

  typedef enum logic {IDLE, SAMPLE} state_t;

  // Smallest 2^k-1 that covers lim-1. lim is given as its low byte: 0 means
  // 256, and 0-1 wraps to 0xFF, which is the mask that 256 needs.
  function automatic logic [7:0] range_mask(input logic [7:0] lim_lo);
    logic [7:0] x;
    x = lim_lo - 8'd1;
    x = x | (x >> 1);
    x = x | (x >> 2);
    x = x | (x >> 4);
    return x;
  endfunction

  state_t          state_q, state_d;
  logic [8:0]      lim_q, lim_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [8:0]      mem_q [DEPTH];
  logic [7:0]      hold_data_q;
  logic            hold_fb_q;
  logic            zero_q;

  logic [7:0]      cand;
  logic            accept;
  logic [7:0]      fb_val;
  logic            push, pop;
  logic [7:0]      push_data;
  logic            push_fb;

  // Range reduction on the live LFSR value against the latched bound.
  always_comb begin
    cand   = rng_q & range_mask(lim_q[7:0]);
    accept = ({1'b0, cand} < lim_q);
    // Used only when rejected. In that case L < 256, and because mask < 2L,
    // cand - L fits below L.
    fb_val = cand - lim_q[7:0];
  end

  // Draw FSM: next state and push request.
  always_comb begin
    state_d   = state_q;
    lim_d     = lim_q;
    tries_d   = tries_q;
    push      = 1'b0;
    push_data = cand;
    push_fb   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (count_q != CNT_FULL)) begin
          lim_d   = (limit == 8'd0) ? 9'd256 : {1'b0, limit};
          tries_d = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (accept) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (tries_q == LAST_TRY) begin
          push      = 1'b1;
          push_data = fb_val;
          push_fb   = 1'b1;
          state_d   = IDLE;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      push    = 1'b0;
    end
  end

  assign rng_step  = (state_q == SAMPLE);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;
  assign rng_zero  = zero_q;

  // When the FIFO is empty, the outputs repeat the last value shown.
  assign out_data     = out_valid ? mem_q[rd_ptr_q][7:0] : hold_data_q;
  assign out_fallback = out_valid ? mem_q[rd_ptr_q][8]   : hold_fb_q;

  // Control state and FIFO bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tries_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      hold_data_q <= 8'd0;
      hold_fb_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      hold_data_q <= out_data;
      hold_fb_q   <= out_fallback;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
      if ((state_q == SAMPLE) && (rng_q == 8'd0) && !flush) zero_q <= 1'b1;
    end
  end

  // Datapath storage: the latched bound and the FIFO entries.
  always_ff @(posedge clock) begin
    lim_q <= lim_d;
    if (push) mem_q[wr_ptr_q] <= {push_fb, push_data};
  end

endmodule

// File: tb/tb_rng_range_draw.sv
// tb_rng_range_draw
//   Directed bench for rng_range_draw. It applies a table of single-draw
//   vectors with hand-computed results. Hand-written sequences then cover
//   reset, latency, a limit change during a draw, FIFO fill/drain across the
//   pointer wrap, flush and reset during a draw, and the rng_zero flag.
module tb_rng_range_draw;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       flush;
  logic [7:0] limit;
  logic [7:0] rng_q;
  logic       rng_step;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_fallback;
  logic [2:0] count;
  logic       rng_zero;

  int vectors = 0;
  int fails   = 0;

  rng_range_draw #(.DEPTH(4), .MAX_TRIES(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .flush        (flush),
    .limit        (limit),
    .rng_q        (rng_q),
    .rng_step     (rng_step),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_fallback (out_fallback),
    .count        (count),
    .rng_zero     (rng_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] lim;
    logic [7:0] rng;
    logic [7:0] exp_data;
    logic       exp_fb;
    int         exp_steps;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts one draw with the LFSR value held constant. Waits, with a bound,
  // until the result shows up in the FIFO. Expects the FIFO empty and the
  // FSM idle on entry.
  task automatic run_draw(input logic [7:0] lim, input logic [7:0] rng,
                          output int steps, output bit done);
    limit     = lim;
    rng_q     = rng;
    enable    = 1'b1;
    out_ready = 1'b0;
    steps     = 0;
    done      = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      enable = 1'b0;
      steps += int'(rng_step);
      if (out_valid) done = 1'b1;
    end
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_v;
    int  steps;
    bit  done;
    bit  hit;

    vecs[0] = '{8'h00, 8'hA5, 8'hA5, 1'b0, 1};
    vecs[1] = '{8'h01, 8'h5A, 8'h00, 1'b0, 1};
    vecs[2] = '{8'h05, 8'h07, 8'h02, 1'b1, 16};
    vecs[3] = '{8'h06, 8'h03, 8'h03, 1'b0, 1};
    vecs[4] = '{8'h0A, 8'h09, 8'h09, 1'b0, 1};
    vecs[5] = '{8'hC8, 8'hFF, 8'h37, 1'b1, 16};
    vecs[6] = '{8'h80, 8'hFF, 8'h7F, 1'b0, 1};
    vecs[7] = '{8'h03, 8'h06, 8'h02, 1'b0, 1};
    vecs[8] = '{8'h03, 8'h07, 8'h00, 1'b1, 16};
    vecs[9] = '{8'hFF, 8'hFE, 8'hFE, 1'b0, 1};

    reset_n   = 1'b0;
    enable    = 1'b0;
    flush     = 1'b0;
    limit     = 8'd0;
    rng_q     = 8'd0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset out_valid", out_valid, 0);
    check("reset count", count, 0);
    check("reset rng_step", rng_step, 0);
    check("reset rng_zero", rng_zero, 0);
    check("reset out_data", out_data, 0);
    check("reset out_fallback", out_fallback, 0);
    reset_n = 1'b1;
    tick();

    // Latency, one rejection, and a limit change during the draw.
    limit  = 8'd6;
    rng_q  = 8'h07;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("lat sample1 rng_step", rng_step, 1);
    check("lat sample1 out_valid", out_valid, 0);
    limit = 8'd2;
    tick();
    check("lat sample2 rng_step", rng_step, 1);
    check("lat sample2 out_valid", out_valid, 0);
    rng_q = 8'h0D;
    tick();
    check("lat out_valid", out_valid, 1);
    check("lat out_data", out_data, 5);
    check("lat out_fallback", out_fallback, 0);
    check("lat idle rng_step", rng_step, 0);
    rng_q = 8'h03;
    tick();
    check("lat stays idle rng_step", rng_step, 0);
    pop_one();
    check("lat pop count", count, 0);
    check("lat hold out_data", out_data, 5);

    // Single-draw vector table.
    for (int i = 0; i < 10; i++) begin
      run_draw(vecs[i].lim, vecs[i].rng, steps, done);
      check($sformatf("vec%0d done", i), done, 1);
      check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d out_fallback", i), out_fallback, vecs[i].exp_fb);
      check($sformatf("vec%0d steps", i), steps, vecs[i].exp_steps);
      check($sformatf("vec%0d count", i), count, 1);
      pop_one();
      check($sformatf("vec%0d pop count", i), count, 0);
      check($sformatf("vec%0d hold data", i), out_data, vecs[i].exp_data);
    end
    check("no rng_zero yet", rng_zero, 0);

    // Fill to DEPTH with the consumer stalled, then drain while refilling.
    limit     = 8'd0;
    enable    = 1'b1;
    out_ready = 1'b0;
    rng_q     = 8'h10;
    for (int c = 0; c < 20; c++) begin
      if (rng_step) q.push_back(rng_q);
      tick();
      rng_q = rng_q + 8'd1;
    end
    check("fill count", count, 4);
    check("fill rng_step idle", rng_step, 0);
    check("fill model size", count, q.size());
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (q.size() == 0) check("drain underflow", 1, 0);
        else begin
          exp_v = q.pop_front();
          check("drain out_data", out_data, exp_v);
        end
      end
      if (rng_step) q.push_back(rng_q);
      tick();
      rng_q = rng_q + 8'd1;
      check("drain count", count, q.size());
    end
    enable = 1'b0;
    for (int c = 0; c < 20 && (out_valid || rng_step); c++) begin
      if (out_valid) begin
        if (q.size() == 0) check("final underflow", 1, 0);
        else begin
          exp_v = q.pop_front();
          check("final out_data", out_data, exp_v);
        end
      end
      if (rng_step) q.push_back(rng_q);
      tick();
    end
    out_ready = 1'b0;
    check("final empty", out_valid, 0);
    check("final leftover", q.size(), 0);

    // LFSR lock-up value while sampling.
    run_draw(8'd10, 8'h00, steps, done);
    check("zero done", done, 1);
    check("zero out_data", out_data, 0);
    check("zero out_fallback", out_fallback, 0);
    check("zero rng_zero", rng_zero, 1);
    rng_q = 8'h33;
    pop_one();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("zero survives flush", rng_zero, 1);

    // Flush during SAMPLE with three entries queued.
    limit  = 8'd0;
    enable = 1'b1;
    hit    = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      tick();
      if (count == 3 && rng_step) hit = 1'b1;
    end
    check("flush setup reached", hit, 1);
    flush = 1'b1;
    tick();
    flush  = 1'b0;
    enable = 1'b0;
    check("flush count", count, 0);
    check("flush out_valid", out_valid, 0);
    check("flush rng_step", rng_step, 0);
    check("flush rng_zero kept", rng_zero, 1);

    // Reset during SAMPLE with three entries queued.
    enable = 1'b1;
    hit    = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      tick();
      if (count == 3 && rng_step) hit = 1'b1;
    end
    check("rst setup reached", hit, 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    enable  = 1'b0;
    check("rst count", count, 0);
    check("rst out_valid", out_valid, 0);
    check("rst rng_step", rng_step, 0);
    check("rst rng_zero", rng_zero, 0);
    check("rst out_data", out_data, 0);
    check("rst out_fallback", out_fallback, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
